// File: rtl/axonerve_sim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axonerve_sim_pkg
// Brief    : Shared types and constants for the AXI memory model and stall LFSR.
// Revision : 1.0
// ============================================================================
package axonerve_sim_pkg;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_WAIT  = 2'd1,
      R_BURST = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] c_lfsr_taps = 16'hB400;
   localparam logic [15:0] c_lfsr_seed = 16'hACE1;

   function automatic logic lfsr_feedback(input logic [15:0] s);
      return ^(s & c_lfsr_taps);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axonerve_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : axonerve_lfsr16
// Brief    : Free-running 16-bit Fibonacci LFSR, reloads the seed on reset.
// Revision : 1.0
// ============================================================================
module axonerve_lfsr16
   import axonerve_sim_pkg::*;
(
   input  logic        ap_clk,
   input  logic        ap_rst_n,
   input  logic [15:0] seed,
   output logic [15:0] state
);

   logic [15:0] r_state;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state <= seed;
      end else begin
         r_state <= {r_state[14:0], lfsr_feedback(r_state)};
      end
   end

   assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/axonerve_axi_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : axonerve_axi_mem_model
// Brief    : AXI4 slave word memory with read latency, stall injection, preload.
// Revision : 1.0
// ============================================================================
module axonerve_axi_mem_model
   import axonerve_sim_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 64,
   parameter int                    DATA_WIDTH  = 512,
   parameter int                    DEPTH_WORDS = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    RD_LATENCY  = 4,
   parameter bit                    STALL_EN    = 1'b0,
   parameter logic [15:0]           STALL_SEED  = c_lfsr_seed
) (
   input  logic                           ap_clk,
   input  logic                           ap_rst_n,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
   input  logic [7:0]                     s_axi_awlen,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
   input  logic                           s_axi_wlast,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   input  logic                           s_axi_arvalid,
   output logic                           s_axi_arready,
   input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
   input  logic [7:0]                     s_axi_arlen,
   output logic                           s_axi_rvalid,
   input  logic                           s_axi_rready,
   output logic [DATA_WIDTH-1:0]          s_axi_rdata,
   output logic                           s_axi_rlast,
   input  logic                           init_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] init_idx,
   input  logic [DATA_WIDTH-1:0]          init_data,
   output logic [31:0]                    rd_beats,
   output logic [31:0]                    wr_beats,
   output logic                           proto_err
);

   localparam int         c_nbytes   = DATA_WIDTH / 8;
   localparam int         c_offb     = $clog2(c_nbytes);
   localparam int         c_iw       = $clog2(DEPTH_WORDS);
   localparam logic [7:0] c_lat_init = (RD_LATENCY > 0) ? 8'(RD_LATENCY - 1) : 8'd0;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

   // Keeps the ready outputs low while reset is asserted
   logic                  r_live;
   logic [15:0]           w_lfsr;
   logic                  w_stall;
   logic [ADDR_WIDTH-1:0] w_ar_off;
   logic [ADDR_WIDTH-1:0] w_aw_off;
   logic [c_iw-1:0]       w_ar_idx;
   logic [c_iw-1:0]       w_aw_idx;
   logic                  w_unused_bits;

   rd_state_t             r_rd_state;
   rd_state_t             w_rd_next;
   logic [c_iw-1:0]       r_rd_idx;
   logic [c_iw-1:0]       w_rd_fetch;
   logic [7:0]            r_rd_len;
   logic [7:0]            r_rd_beat;
   logic [7:0]            r_lat_cnt;
   logic                  r_rd_hold;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [31:0]           r_rd_beats;
   logic                  w_ar_hs;
   logic                  w_r_hs;

   wr_state_t             r_wr_state;
   wr_state_t             w_wr_next;
   logic [c_iw-1:0]       r_wr_idx;
   logic [7:0]            r_wr_len;
   logic [7:0]            r_wr_beat;
   logic [31:0]           r_wr_beats;
   logic                  r_proto_err;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_w_last;

   axonerve_lfsr16 u_lfsr (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .seed     (STALL_SEED),
      .state    (w_lfsr)
   );

   assign w_stall       = STALL_EN && (w_lfsr[1:0] == 2'b00);
   assign w_ar_off      = s_axi_araddr - BASE_ADDR;
   assign w_aw_off      = s_axi_awaddr - BASE_ADDR;
   assign w_ar_idx      = w_ar_off[c_offb +: c_iw];
   assign w_aw_idx      = w_aw_off[c_offb +: c_iw];
   assign w_unused_bits = ^{w_ar_off, w_aw_off, w_lfsr[15:2]};

   // ---------------------------------------------------------------- read
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_rd_state <= R_IDLE;
      end else begin
         r_rd_state <= w_rd_next;
      end
   end

   always_comb begin
      w_rd_next     = r_rd_state;
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      s_axi_rlast   = 1'b0;
      case (r_rd_state)
         R_IDLE: begin
            s_axi_arready = r_live;
            if (s_axi_arvalid && r_live) begin
               w_rd_next = (RD_LATENCY > 0) ? R_WAIT : R_BURST;
            end
         end
         R_WAIT: begin
            if (r_lat_cnt == 8'd0) begin
               w_rd_next = R_BURST;
            end
         end
         R_BURST: begin
            // A beat already on the bus must be held regardless of the stall
            s_axi_rvalid = r_rd_hold || !w_stall;
            s_axi_rlast  = (r_rd_beat == r_rd_len);
            if (s_axi_rvalid && s_axi_rready && s_axi_rlast) begin
               w_rd_next = R_IDLE;
            end
         end
         default: w_rd_next = R_IDLE;
      endcase
   end

   assign w_ar_hs = s_axi_arvalid && s_axi_arready;
   assign w_r_hs  = s_axi_rvalid && s_axi_rready;

   always_comb begin
      w_rd_fetch = r_rd_idx;
      if (r_rd_state == R_IDLE) begin
         w_rd_fetch = w_ar_idx;
      end else if (w_r_hs) begin
         w_rd_fetch = r_rd_idx + 1'b1;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_rd_idx   <= '0;
         r_rd_len   <= 8'd0;
         r_rd_beat  <= 8'd0;
         r_lat_cnt  <= 8'd0;
         r_rd_hold  <= 1'b0;
         r_rdata    <= '0;
         r_rd_beats <= 32'd0;
         r_live     <= 1'b0;
      end else begin
         r_live    <= 1'b1;
         r_rd_hold <= s_axi_rvalid && !s_axi_rready;
         if (w_ar_hs) begin
            r_rd_idx  <= w_ar_idx;
            r_rd_len  <= s_axi_arlen;
            r_rd_beat <= 8'd0;
            r_lat_cnt <= c_lat_init;
         end else if (w_r_hs) begin
            r_rd_idx  <= r_rd_idx + 1'b1;
            r_rd_beat <= r_rd_beat + 8'd1;
         end
         if ((r_rd_state == R_WAIT) && (r_lat_cnt != 8'd0)) begin
            r_lat_cnt <= r_lat_cnt - 8'd1;
         end
         // Prefetch the beat shown next cycle; a same-edge write lands after this read
         if (((r_rd_state != R_IDLE) || w_ar_hs) && !(s_axi_rvalid && !s_axi_rready)) begin
            r_rdata <= r_mem[w_rd_fetch];
         end
         if (w_r_hs) begin
            r_rd_beats <= r_rd_beats + 32'd1;
         end
      end
   end

   // --------------------------------------------------------------- write
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_wr_state <= W_IDLE;
      end else begin
         r_wr_state <= w_wr_next;
      end
   end

   assign w_w_last = (r_wr_beat == r_wr_len);

   always_comb begin
      w_wr_next     = r_wr_state;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      case (r_wr_state)
         W_IDLE: begin
            s_axi_awready = r_live;
            if (s_axi_awvalid && r_live) begin
               w_wr_next = W_DATA;
            end
         end
         W_DATA: begin
            s_axi_wready = !w_stall;
            if (s_axi_wvalid && s_axi_wready && w_w_last) begin
               w_wr_next = W_RESP;
            end
         end
         W_RESP: begin
            s_axi_bvalid = 1'b1;
            if (s_axi_bready) begin
               w_wr_next = W_IDLE;
            end
         end
         default: w_wr_next = W_IDLE;
      endcase
   end

   assign w_aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_w_hs  = s_axi_wvalid && s_axi_wready;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_wr_idx    <= '0;
         r_wr_len    <= 8'd0;
         r_wr_beat   <= 8'd0;
         r_wr_beats  <= 32'd0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_aw_hs) begin
            r_wr_idx  <= w_aw_idx;
            r_wr_len  <= s_axi_awlen;
            r_wr_beat <= 8'd0;
         end else if (w_w_hs) begin
            r_wr_idx  <= r_wr_idx + 1'b1;
            r_wr_beat <= r_wr_beat + 8'd1;
         end
         if (w_w_hs) begin
            r_wr_beats <= r_wr_beats + 32'd1;
            if (s_axi_wlast != w_w_last) begin
               r_proto_err <= 1'b1;
            end
         end
      end
   end

   // Storage survives reset; the AXI write is ordered last so it wins a collision
   always_ff @(posedge ap_clk) begin
      if (init_we) begin
         r_mem[init_idx] <= init_data;
      end
      if (w_w_hs) begin
         for (int b = 0; b < c_nbytes; b++) begin
            if (s_axi_wstrb[b]) begin
               r_mem[r_wr_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
         end
      end
   end

   assign s_axi_rdata = r_rdata;
   assign rd_beats    = r_rd_beats;
   assign wr_beats    = r_wr_beats;
   assign proto_err   = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_axonerve_axi_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_axonerve_axi_mem_model
// Brief    : Scoreboard bench: plain instance (latency 4) and a stalling instance.
// Revision : 1.0
// ============================================================================
module tb_axonerve_axi_mem_model;

   typedef struct {
      logic [511:0] data;
      logic         last;
   } rexp_t;

   typedef struct {
      logic [31:0] beats;
      logic        perr;
   } bexp_t;

   logic ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   int cyc    = 0;
   int n_tests = 0;
   int n_fail  = 0;
   int hs_cyc0 = 0;
   always @(posedge ap_clk) cyc <= cyc + 1;

   rexp_t rq0[$];
   rexp_t rq1[$];
   bexp_t bq0[$];
   logic [511:0] wdat [4];

   // instance 0: 512-bit, depth 1024, latency 4, no stalls
   logic         rst_n0;
   logic         awvalid0, awready0, wvalid0, wready0, wlast0, bvalid0, bready0;
   logic [63:0]  awaddr0, araddr0, wstrb0;
   logic [7:0]   awlen0, arlen0;
   logic [511:0] wdata0, rdata0, init_data0;
   logic         arvalid0, arready0, rvalid0, rready0, rlast0, init_we0, proto_err0;
   logic [9:0]   init_idx0;
   logic [31:0]  rd_beats0, wr_beats0;

   // instance 1: 64-bit, depth 128, latency 2, stalls enabled
   logic         rst_n1;
   logic         awvalid1, awready1, wvalid1, wready1, wlast1, bvalid1, bready1;
   logic [31:0]  awaddr1, araddr1;
   logic [7:0]   awlen1, arlen1, wstrb1;
   logic [63:0]  wdata1, rdata1, init_data1;
   logic         arvalid1, arready1, rvalid1, rready1, rlast1, init_we1, proto_err1;
   logic [6:0]   init_idx1;
   logic [31:0]  rd_beats1, wr_beats1;

   axonerve_axi_mem_model #(
      .ADDR_WIDTH(64), .DATA_WIDTH(512), .DEPTH_WORDS(1024), .BASE_ADDR(64'h0),
      .RD_LATENCY(4), .STALL_EN(1'b0), .STALL_SEED(16'hACE1)
   ) u_dut0 (
      .ap_clk(ap_clk), .ap_rst_n(rst_n0),
      .s_axi_awvalid(awvalid0), .s_axi_awready(awready0), .s_axi_awaddr(awaddr0), .s_axi_awlen(awlen0),
      .s_axi_wvalid(wvalid0), .s_axi_wready(wready0), .s_axi_wdata(wdata0), .s_axi_wstrb(wstrb0),
      .s_axi_wlast(wlast0), .s_axi_bvalid(bvalid0), .s_axi_bready(bready0),
      .s_axi_arvalid(arvalid0), .s_axi_arready(arready0), .s_axi_araddr(araddr0), .s_axi_arlen(arlen0),
      .s_axi_rvalid(rvalid0), .s_axi_rready(rready0), .s_axi_rdata(rdata0), .s_axi_rlast(rlast0),
      .init_we(init_we0), .init_idx(init_idx0), .init_data(init_data0),
      .rd_beats(rd_beats0), .wr_beats(wr_beats0), .proto_err(proto_err0)
   );

   axonerve_axi_mem_model #(
      .ADDR_WIDTH(32), .DATA_WIDTH(64), .DEPTH_WORDS(128), .BASE_ADDR(32'h0),
      .RD_LATENCY(2), .STALL_EN(1'b1), .STALL_SEED(16'hACE1)
   ) u_dut1 (
      .ap_clk(ap_clk), .ap_rst_n(rst_n1),
      .s_axi_awvalid(awvalid1), .s_axi_awready(awready1), .s_axi_awaddr(awaddr1), .s_axi_awlen(awlen1),
      .s_axi_wvalid(wvalid1), .s_axi_wready(wready1), .s_axi_wdata(wdata1), .s_axi_wstrb(wstrb1),
      .s_axi_wlast(wlast1), .s_axi_bvalid(bvalid1), .s_axi_bready(bready1),
      .s_axi_arvalid(arvalid1), .s_axi_arready(arready1), .s_axi_araddr(araddr1), .s_axi_arlen(arlen1),
      .s_axi_rvalid(rvalid1), .s_axi_rready(rready1), .s_axi_rdata(rdata1), .s_axi_rlast(rlast1),
      .init_we(init_we1), .init_idx(init_idx1), .init_data(init_data1),
      .rd_beats(rd_beats1), .wr_beats(wr_beats1), .proto_err(proto_err1)
   );

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: actual=timeout required=completion", name);
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic push0(input logic [511:0] d, input logic last);
      rexp_t e;
      e.data = d;
      e.last = last;
      rq0.push_back(e);
   endtask

   task automatic push1(input logic [63:0] d, input logic last);
      rexp_t e;
      e.data = {448'd0, d};
      e.last = last;
      rq1.push_back(e);
   endtask

   task automatic preload0(input int idx, input logic [511:0] d);
      init_we0 = 1'b1; init_idx0 = 10'(idx); init_data0 = d;
      tick();
      init_we0 = 1'b0;
   endtask

   task automatic preload1(input int idx, input logic [63:0] d);
      init_we1 = 1'b1; init_idx1 = 7'(idx); init_data1 = d;
      tick();
      init_we1 = 1'b0;
   endtask

   task automatic ar0(input logic [63:0] addr, input logic [7:0] len);
      int n = 0;
      araddr0 = addr; arlen0 = len; arvalid0 = 1'b1;
      while (!arready0 && n < 100) begin tick(); n++; end
      if (n >= 100) timeout("ar0_handshake");
      hs_cyc0 = cyc;
      tick();
      arvalid0 = 1'b0;
   endtask

   task automatic ar1(input logic [31:0] addr, input logic [7:0] len);
      int n = 0;
      araddr1 = addr; arlen1 = len; arvalid1 = 1'b1;
      while (!arready1 && n < 100) begin tick(); n++; end
      if (n >= 100) timeout("ar1_handshake");
      tick();
      arvalid1 = 1'b0;
   endtask

   task automatic axi_write0(input logic [63:0] addr, input logic [7:0] len, input logic [63:0] strb,
                             input int last_at, input logic [31:0] exp_beats, input logic exp_perr);
      int    n = 0;
      bexp_t be;
      be.beats = exp_beats;
      be.perr  = exp_perr;
      bq0.push_back(be);
      awaddr0 = addr; awlen0 = len; awvalid0 = 1'b1;
      while (!awready0 && n < 100) begin tick(); n++; end
      if (n >= 100) timeout("aw0_handshake");
      tick();
      awvalid0 = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wvalid0 = 1'b1; wdata0 = wdat[i]; wstrb0 = strb; wlast0 = (i == last_at);
         n = 0;
         while (!wready0 && n < 100) begin tick(); n++; end
         if (n >= 100) timeout("w0_handshake");
         tick();
      end
      wvalid0 = 1'b0; wlast0 = 1'b0;
   endtask

   task automatic wait_idle0();
      int n = 0;
      while ((rq0.size() != 0 || bq0.size() != 0) && n < 300) begin tick(); n++; end
      if (n >= 300) timeout("wait_idle0");
   endtask

   task automatic drain1(input int stop_at, input bit rnd);
      int n = 0;
      while (rq1.size() > stop_at && n < 3000) begin
         rready1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         n++;
      end
      if (n >= 3000) timeout("drain1");
   endtask

   // monitor for instance 0: first-beat latency, R beats and B responses
   logic  prev_rv0 = 1'b0;
   rexp_t m0_r;
   bexp_t m0_b;
   always @(negedge ap_clk) begin
      if (!rst_n0) begin
         prev_rv0 = 1'b0;
      end else begin
         if (rvalid0 && !prev_rv0) chk("rd_latency", 512'(cyc - hs_cyc0), 512'd5);
         if (rvalid0 && rready0) begin
            if (rq0.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_rbeat0: actual=rvalid required=idle");
            end else begin
               m0_r = rq0.pop_front();
               chk("rdata0", rdata0, m0_r.data);
               chk("rlast0", {511'd0, rlast0}, {511'd0, m0_r.last});
            end
         end
         if (bvalid0 && bready0) begin
            if (bq0.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_bvalid0: actual=bvalid required=idle");
            end else begin
               m0_b = bq0.pop_front();
               chk("bresp_wr_beats", {480'd0, wr_beats0}, {480'd0, m0_b.beats});
               chk("bresp_proto_err", {511'd0, proto_err0}, {511'd0, m0_b.perr});
            end
         end
         prev_rv0 = rvalid0;
      end
   end

   // monitor for instance 1: hold rule under stalls plus R beats
   logic        prev_hold1 = 1'b0;
   logic [63:0] prev_rdata1 = 64'd0;
   rexp_t       m1_r;
   always @(negedge ap_clk) begin
      if (!rst_n1) begin
         prev_hold1 = 1'b0;
      end else begin
         if (prev_hold1) begin
            chk("stall_rvalid_held", {511'd0, rvalid1}, 512'd1);
            chk("stall_rdata_stable", {448'd0, rdata1}, {448'd0, prev_rdata1});
         end
         if (rvalid1 && rready1) begin
            if (rq1.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_rbeat1: actual=rvalid required=idle");
            end else begin
               m1_r = rq1.pop_front();
               chk("rdata1", {448'd0, rdata1}, m1_r.data);
               chk("rlast1", {511'd0, rlast1}, {511'd0, m1_r.last});
            end
         end
         prev_hold1  = rvalid1 && !rready1;
         prev_rdata1 = rdata1;
      end
   end

   initial begin
      rst_n0 = 1'b0; rst_n1 = 1'b0;
      awvalid0 = 0; awaddr0 = '0; awlen0 = '0; wvalid0 = 0; wdata0 = '0; wstrb0 = '0; wlast0 = 0;
      bready0 = 1; arvalid0 = 0; araddr0 = '0; arlen0 = '0; rready0 = 1;
      init_we0 = 0; init_idx0 = '0; init_data0 = '0;
      awvalid1 = 0; awaddr1 = '0; awlen1 = '0; wvalid1 = 0; wdata1 = '0; wstrb1 = '0; wlast1 = 0;
      bready1 = 1; arvalid1 = 0; araddr1 = '0; arlen1 = '0; rready1 = 0;
      init_we1 = 0; init_idx1 = '0; init_data1 = '0;

      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      chk("rst_arready0", {511'd0, arready0}, 512'd0);
      chk("rst_awready0", {511'd0, awready0}, 512'd0);
      chk("rst_rvalid0", {511'd0, rvalid0}, 512'd0);
      chk("rst_wready0", {511'd0, wready0}, 512'd0);
      chk("rst_bvalid0", {511'd0, bvalid0}, 512'd0);
      chk("rst_rdata0", rdata0, 512'd0);
      chk("rst_rd_beats0", {480'd0, rd_beats0}, 512'd0);
      chk("rst_proto_err0", {511'd0, proto_err0}, 512'd0);
      chk("rst_rvalid1", {511'd0, rvalid1}, 512'd0);

      @(posedge ap_clk); #1;
      rst_n0 = 1'b1; rst_n1 = 1'b1;
      tick(); tick();

      for (int i = 0; i < 8; i++) preload0(i, 512'(i));
      preload0(1022, 512'h3FE);
      preload0(1023, 512'h3FF);

      // 4-beat read from word 0
      for (int i = 0; i < 4; i++) push0(512'(i), i == 3);
      ar0(64'h0, 8'd3);
      wait_idle0();
      chk("rd_beats_after_burst", {480'd0, rd_beats0}, 512'd4);

      // 2-beat full-strobe write at 0x80 (word 2), then read back
      wdat[0] = {16{32'hAAAA_0001}};
      wdat[1] = {16{32'hBBBB_0002}};
      axi_write0(64'h80, 8'd1, {64{1'b1}}, 1, 32'd2, 1'b0);
      wait_idle0();
      push0({16{32'hAAAA_0001}}, 1'b0);
      push0({16{32'hBBBB_0002}}, 1'b1);
      ar0(64'h80, 8'd1);
      wait_idle0();
      chk("rd_beats_after_readback", {480'd0, rd_beats0}, 512'd6);

      // single-byte strobe into word 5 (held 0x05)
      wdat[0] = {512{1'b1}};
      axi_write0(64'h140, 8'd0, 64'h1, 0, 32'd3, 1'b0);
      wait_idle0();
      push0(512'hFF, 1'b1);
      ar0(64'h140, 8'd0);
      wait_idle0();

      // index wrap from DEPTH-2
      push0(512'h3FE, 1'b0);
      push0(512'h3FF, 1'b0);
      push0(512'h0, 1'b0);
      push0(512'h1, 1'b1);
      ar0(64'hFF80, 8'd3);
      wait_idle0();

      // early wlast on a 4-beat write sets the sticky error
      for (int i = 0; i < 4; i++) wdat[i] = 512'(32'hC000 + i);
      axi_write0(64'h200, 8'd3, {64{1'b1}}, 1, 32'd7, 1'b1);
      wait_idle0();
      repeat (5) tick();
      chk("proto_err_sticky", {511'd0, proto_err0}, 512'd1);

      // reset clears flags and counters but keeps memory
      rst_n0 = 1'b0;
      #1;
      chk("rst2_proto_err0", {511'd0, proto_err0}, 512'd0);
      chk("rst2_wr_beats0", {480'd0, wr_beats0}, 512'd0);
      tick();
      rst_n0 = 1'b1;
      tick();
      push0({16{32'hAAAA_0001}}, 1'b1);
      ar0(64'h80, 8'd0);
      wait_idle0();

      // stalling instance: 64-beat read with random rready
      for (int i = 0; i < 64; i++) preload1(i, 64'h5A00_0000_0000_0000 | 64'(i));
      for (int i = 0; i < 64; i++) push1(64'h5A00_0000_0000_0000 | 64'(i), i == 63);
      ar1(32'h0, 8'd63);
      drain1(0, 1'b1);
      rready1 = 1'b0;
      tick(); tick();
      chk("rd_beats1_64", {480'd0, rd_beats1}, 512'd64);

      // reset in the middle of a burst
      for (int i = 0; i < 64; i++) push1(64'h5A00_0000_0000_0000 | 64'(i), i == 63);
      ar1(32'h0, 8'd63);
      drain1(40, 1'b1);
      #2;
      rst_n1 = 1'b0;
      #1;
      chk("midburst_rst_rvalid1", {511'd0, rvalid1}, 512'd0);
      chk("midburst_rst_rd_beats1", {480'd0, rd_beats1}, 512'd0);
      rq1.delete();
      rready1 = 1'b0;
      tick(); tick();
      rst_n1 = 1'b1;
      tick(); tick();
      for (int i = 20; i < 24; i++) push1(64'h5A00_0000_0000_0000 | 64'(i), i == 23);
      ar1(32'hA0, 8'd3);
      drain1(0, 1'b0);
      tick();

      chk("rq0_drained", 512'(rq0.size()), 512'd0);
      chk("rq1_drained", 512'(rq1.size()), 512'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
